pwm_capture: RTL and testbench

//  Receive-side counterpart of the PWM generator. Measures an incoming PWM waveform
//  and reports its high time and period in clk cycles. Used for loopback self-test
//  of the PWM output and for reading external PWM sources (servo/fan tach, 200 Hz class).

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 29 ++
 rtl/pwm_capture.sv | 141 ++++++++++++++
 tb/tb_pwm_capture.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// State encoding is fixed here so both sides and any debug readback agree on it.
package pwm_pkg;

    localparam int unsigned PWM_PERIOD_CYC = 500_000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        HIGH = ST_HIGH,
        LOW  = ST_LOW
    } cap_state_e;

    typedef struct packed {
        logic rise;
        logic fall;
    } edge_t;

    function automatic edge_t edge_det(input logic s, input logic s_d);
        edge_t e;
        e.rise = s & ~s_d;
        e.fall = ~s & s_d;
        return e;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous pin; resets to 0.
module sync_2ff (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input,
// flagging an input that stops toggling for TIMEOUT_CYC cycles.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] duty,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             stuck_high,
    output logic             stuck_low
);

    localparam logic [64:0]      CNT_LIM = 65'd1 << CNT_W;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    generate
        if (65'(TIMEOUT_CYC) >= CNT_LIM) begin : g_bad_timeout
            $error("pwm_capture: TIMEOUT_CYC must be below 2**CNT_W");
        end
    endgenerate

    logic  s;
    logic  s_d_q, s_d_d;
    edge_t e;
    logic  timeout;

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             stuck_high_q, stuck_high_d;
    logic             stuck_low_q, stuck_low_d;

    sync_2ff u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (pwm_in),
        .q      (s)
    );

    always_comb begin
        s_d_d = s;
        e     = edge_det(s, s_d_q);
        // >= rather than == so a fall landing on the last count still times out next cycle
        timeout = (cnt_q >= TO_LAST) && !e.rise && !e.fall;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        high_cnt_d   = high_cnt_q;
        duty_d       = duty_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;

        unique case (state_q)
            IDLE: begin
                if (e.rise) begin
                    state_d = HIGH;
                    cnt_d   = ONE;
                end else if (!s) begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HIGH: begin
                cnt_d = cnt_q + ONE;
                if (e.fall) begin
                    state_d    = LOW;
                    high_cnt_d = cnt_q;
                end
            end
            LOW: begin
                if (e.rise) begin
                    state_d      = HIGH;
                    cnt_d        = ONE;
                    duty_d       = high_cnt_q;
                    period_d     = cnt_q;
                    valid_d      = 1'b1;
                    stuck_high_d = 1'b0;
                    stuck_low_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Results are held; the next measurement restarts from a clean first rise.
        if (timeout) begin
            state_d      = IDLE;
            cnt_d        = '0;
            stuck_high_d = s;
            stuck_low_d  = ~s;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_d_q        <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            high_cnt_q   <= '0;
            duty_q       <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            s_d_q        <= s_d_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            high_cnt_q   <= high_cnt_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign duty       = duty_q;
    assign period     = period_q;
    assign valid      = valid_q;
    assign stuck_high = stuck_high_q;
    assign stuck_low  = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a short timeout so stuck cases fit in a few thousand cycles.
module tb_pwm_capture;

    localparam int unsigned TO = 1000;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] duty;
    logic [CW-1:0] period;
    logic          valid;
    logic          stuck_high;
    logic          stuck_low;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int vtotal   = 0;
    int vlast    = 0;
    int vgap     = 0;
    int base     = 0;

    pwm_capture #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .pwm_in     (pwm_in),
        .duty       (duty),
        .period     (period),
        .valid      (valid),
        .stuck_high (stuck_high),
        .stuck_low  (stuck_low)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Valid pulse bookkeeping: total count and spacing between consecutive pulses.
    always @(posedge clk) begin
        #1;
        if (valid) begin
            vgap   = cyc - vlast;
            vlast  = cyc;
            vtotal = vtotal + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic pat(input int h, input int l, input int reps);
        repeat (reps) begin
            drv(1'b1, h);
            drv(1'b0, l);
        end
    endtask

    initial begin
        // reset values, with the pin high to show it is ignored during reset
        pwm_in = 1'b1;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_duty", duty, 0);
        chk("rst_period", period, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_stuck_high", {31'd0, stuck_high}, 0);
        chk("rst_stuck_low", {31'd0, stuck_low}, 0);

        // held low from reset
        pwm_in = 1'b0;
        resetn = 1'b1;
        base   = vtotal;
        repeat (990) @(negedge clk);
        chk("low_pre_timeout", {31'd0, stuck_low}, 0);
        repeat (20) @(negedge clk);
        chk("low_stuck_low", {31'd0, stuck_low}, 1);
        chk("low_stuck_high", {31'd0, stuck_high}, 0);
        chk("low_no_valid", vtotal - base, 0);
        chk("low_duty", duty, 0);
        chk("low_period", period, 0);

        // H=1 L=9: first rise is partial, then a result every 10 cycles
        base = vtotal;
        pat(1, 9, 6);
        chk("h1_count", vtotal - base, 5);
        chk("h1_duty", duty, 1);
        chk("h1_period", period, 10);
        chk("h1_gap", vgap, 10);
        chk("h1_stuck_low_clr", {31'd0, stuck_low}, 0);

        // loopback-shaped 25% duty waveform
        base = vtotal;
        pat(125, 375, 4);
        chk("q_count", vtotal - base, 4);
        chk("q_duty", duty, 125);
        chk("q_period", period, 500);
        chk("q_gap", vgap, 500);

        // period of TO-1: each rise lands in the timeout cycle and wins
        base = vtotal;
        pat(100, 899, 3);
        drv(1'b1, 5);
        chk("edge_count", vtotal - base, 4);
        chk("edge_duty", duty, 100);
        chk("edge_period", period, 999);
        chk("edge_gap", vgap, 999);
        chk("edge_stuck_low", {31'd0, stuck_low}, 0);
        chk("edge_stuck_high", {31'd0, stuck_high}, 0);

        // one cycle longer: timeout fires first, results held
        drv(1'b1, 95);
        drv(1'b0, 900);
        drv(1'b1, 5);
        chk("over_stuck_low", {31'd0, stuck_low}, 1);
        chk("over_count", vtotal - base, 4);
        chk("over_period_hold", period, 999);
        chk("over_duty_hold", duty, 100);

        // reset in the middle of a high phase
        drv(1'b1, 20);
        resetn = 1'b0;
        #1;
        chk("mid_rst_duty", duty, 0);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_stuck_low", {31'd0, stuck_low}, 0);
        chk("mid_rst_valid", {31'd0, valid}, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        base   = vtotal;
        drv(1'b1, 300);
        drv(1'b0, 200);
        chk("post_rst_one_rise", vtotal - base, 0);
        pat(300, 200, 1);
        chk("post_rst_two_rise", vtotal - base, 1);
        pat(300, 200, 1);
        chk("post_rst_count", vtotal - base, 2);
        chk("post_rst_duty", duty, 300);
        chk("post_rst_period", period, 500);

        // forced high after a steady 300/200 waveform
        base = vtotal;
        drv(1'b1, 900);
        chk("hi_pre_timeout", {31'd0, stuck_high}, 0);
        chk("hi_last_valid", vtotal - base, 1);
        drv(1'b1, 200);
        chk("hi_stuck_high", {31'd0, stuck_high}, 1);
        chk("hi_stuck_low", {31'd0, stuck_low}, 0);
        chk("hi_duty_hold", duty, 300);
        chk("hi_period_hold", period, 500);
        drv(1'b0, 200);
        drv(1'b1, 300);
        drv(1'b0, 200);
        chk("rel_still_stuck", {31'd0, stuck_high}, 1);
        chk("rel_no_valid", vtotal - base, 1);
        drv(1'b1, 300);
        drv(1'b0, 200);
        chk("rel_stuck_clr", {31'd0, stuck_high}, 0);
        chk("rel_count", vtotal - base, 2);
        chk("rel_duty", duty, 300);
        chk("rel_period", period, 500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
